vga_sync_pulses: RTL and testbench

- Free-running VGA timing generator; the stage directly upstream of the porch-shaping stage.
- Produces raw active-region HSync/VSync plus the column/row counters that the porch stage consumes to carve front porch, sync pulse and back porch.
- Default timing 800x525 total, 640x480 visible, one count per enabled pixel-clock cycle.

---
 rtl/vga_timing_pkg.sv | 18 +
 rtl/vga_wrap_counter.sv | 25 ++
 rtl/vga_sync_pulses.sv | 80 ++++++++
 tb/tb_vga_sync_pulses.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants for the sync generator and the porch stage.
package vga_timing_pkg;

  localparam int VGA_TOTAL_COLS  = 800;
  localparam int VGA_TOTAL_ROWS  = 525;
  localparam int VGA_ACTIVE_COLS = 640;
  localparam int VGA_ACTIVE_ROWS = 480;

  localparam int VGA_H_FRONT = 18;
  localparam int VGA_H_BACK  = 50;
  localparam int VGA_H_PULSE = 92;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_BACK  = 33;
  localparam int VGA_V_PULSE = 2;

  localparam int VGA_CNT_W = 10;

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-N up counter with enable, synchronous reset and terminal-count flag.
module vga_wrap_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign tc = (count == LAST);

  // Advance on enable, wrapping to zero after the last value.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (en)
      count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/vga_sync_pulses.sv
// Free-running VGA timing generator: column/row counters plus active-high
// visible-region syncs. Optional macro VGA_FRAME_COUNT_EN adds an 8-bit
// frame counter output.
module vga_sync_pulses
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS  = VGA_TOTAL_COLS,
  parameter int TOTAL_ROWS  = VGA_TOTAL_ROWS,
  parameter int ACTIVE_COLS = VGA_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = VGA_ACTIVE_ROWS,
  parameter int CNT_W       = VGA_CNT_W
) (
  input  logic             CLK,
  input  logic             i_Reset,
  input  logic             i_Pix_En,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Active,
  output logic             o_Frame_Start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]       o_Frame_Count
`endif
);

  localparam logic [CNT_W-1:0] ACT_COLS = CNT_W'(ACTIVE_COLS);
  localparam logic [CNT_W-1:0] ACT_ROWS = CNT_W'(ACTIVE_ROWS);

  logic col_tc;
  logic row_tc;
  logic row_en;
  logic frame_wrap;

  // Rows step only on the enabled cycle where the column counter wraps.
  assign row_en     = i_Pix_En & col_tc;
  assign frame_wrap = row_en & row_tc;

  vga_wrap_counter #(.N(TOTAL_COLS), .W(CNT_W)) u_col_cnt (
    .clk   (CLK),
    .rst   (i_Reset),
    .en    (i_Pix_En),
    .count (o_Col_Count),
    .tc    (col_tc)
  );

  vga_wrap_counter #(.N(TOTAL_ROWS), .W(CNT_W)) u_row_cnt (
    .clk   (CLK),
    .rst   (i_Reset),
    .en    (row_en),
    .count (o_Row_Count),
    .tc    (row_tc)
  );

  // Syncs decode the registered counters so they never skew from them.
  assign o_HSync  = (o_Col_Count < ACT_COLS);
  assign o_VSync  = (o_Row_Count < ACT_ROWS);
  assign o_Active = o_HSync & o_VSync;

  // Frame-start pulse registered alongside the wrap to (0,0); a gapped
  // enable drops it after exactly one cycle.
  always_ff @(posedge CLK) begin
    if (i_Reset)
      o_Frame_Start <= 1'b0;
    else
      o_Frame_Start <= frame_wrap;
  end

`ifdef VGA_FRAME_COUNT_EN
  // Frame counter bumps on the same edge that raises the frame-start pulse.
  always_ff @(posedge CLK) begin
    if (i_Reset)
      o_Frame_Count <= 8'd0;
    else if (frame_wrap)
      o_Frame_Count <= o_Frame_Count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_sync_pulses.sv
// Self-checking bench for vga_sync_pulses using a reduced 10x6 timing.
module tb_vga_sync_pulses;

  localparam int TC    = 10;
  localparam int TR    = 6;
  localparam int AC    = 7;
  localparam int AR    = 4;
  localparam int CW    = 4;
  localparam int FRAME = TC * TR;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          hs, vs, act, fs;
  logic [CW-1:0] col, row;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0]    fc;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model: number of enabled cycles since the last reset.
  longint n_m   = 0;
  bit     fs_m  = 0;
  int     fc_m  = 0;

  always #5 clk = ~clk;

  vga_sync_pulses #(
    .TOTAL_COLS (TC),
    .TOTAL_ROWS (TR),
    .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR),
    .CNT_W      (CW)
  ) dut (
    .CLK          (clk),
    .i_Reset      (rst),
    .i_Pix_En     (en),
    .o_HSync      (hs),
    .o_VSync      (vs),
    .o_Col_Count  (col),
    .o_Row_Count  (row),
    .o_Active     (act),
    .o_Frame_Start(fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .o_Frame_Count(fc)
`endif
  );

  task automatic chk(input string name, input longint actual, input longint expected);
    chk_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
  endtask

  // Drive one cycle, advance the model, and compare every output to it.
  task automatic step(input bit r, input bit e);
    int mc, mr;
    rst = r;
    en  = e;
    @(posedge clk);
    if (r) begin
      n_m = 0; fs_m = 0; fc_m = 0;
    end else if (e) begin
      n_m++;
      fs_m = (n_m % FRAME) == 0;
      if (fs_m) fc_m = (fc_m + 1) % 256;
    end else begin
      fs_m = 0;
    end
    @(negedge clk);
    mc = int'(n_m % TC);
    mr = int'((n_m / TC) % TR);
    chk("col", col, mc);
    chk("row", row, mr);
    chk("hsync", hs, mc < AC);
    chk("vsync", vs, mr < AR);
    chk("active", act, (mc < AC) && (mr < AR));
    chk("frame_start", fs, fs_m);
`ifdef VGA_FRAME_COUNT_EN
    chk("frame_count", fc, fc_m);
`endif
  endtask

  typedef struct {
    bit rst;
    bit en;
    int col;
    int row;
    bit fs;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int act_cnt;
    int cyc;
    int pulses;
    bit seen;

    tbl[0]  = '{1, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 2, 0, 0};
    tbl[4]  = '{0, 1, 3, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 0};
    tbl[8]  = '{0, 1, 2, 0, 0};
    tbl[9]  = '{0, 1, 3, 0, 0};
    tbl[10] = '{0, 1, 4, 0, 0};
    tbl[11] = '{0, 1, 5, 0, 0};
    tbl[12] = '{0, 1, 6, 0, 0};
    tbl[13] = '{0, 1, 7, 0, 0};
    tbl[14] = '{0, 1, 8, 0, 0};
    tbl[15] = '{0, 1, 9, 0, 0};
    tbl[16] = '{0, 1, 0, 1, 0};
    tbl[17] = '{0, 0, 0, 1, 0};

    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);

    // Fixed vectors: reset, gapped enable, mid-line reset, line wrap.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].en);
      chk("tbl_col", col, tbl[i].col);
      chk("tbl_row", row, tbl[i].row);
      chk("tbl_fs", fs, tbl[i].fs);
    end

    // Frame wrap followed by a gap: pulse must be exactly one clock.
    step(1, 1);
    for (int i = 0; i < FRAME - 1; i++) step(0, 1);
    chk("last_col", col, TC - 1);
    chk("last_row", row, TR - 1);
    step(0, 1);
    chk("wrap_fs_hi", fs, 1);
    chk("wrap_col0", col, 0);
    chk("wrap_row0", row, 0);
    step(0, 0);
    chk("gap_fs_lo", fs, 0);
    step(0, 1);
    chk("after_gap_fs_lo", fs, 0);

    // Mid-frame reset: back to (0,0), no pulse, next pulse after a full frame.
    while (!(col == 3 && row == 2)) step(0, 1);
    step(1, 1);
    chk("midrst_col", col, 0);
    chk("midrst_row", row, 0);
    chk("midrst_fs", fs, 0);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 3 * FRAME) begin
      step(0, 1);
      cyc++;
      if (fs) seen = 1;
    end
    chk("midrst_pulse_seen", seen, 1);
    chk("midrst_pulse_dist", cyc, FRAME);

    // Active pixel count over one frame of states.
    step(1, 1);
    act_cnt = act ? 1 : 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      step(0, 1);
      if (act) act_cnt++;
    end
    chk("active_per_frame", act_cnt, AC * AR);

    // Randomized enable/reset traffic against the model.
    step(1, 0);
    for (int i = 0; i < 6000; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7));

`ifdef VGA_FRAME_COUNT_EN
    // 257 frames: counter reads 1, wraps to 0 at frame 256, reads 1 at 257.
    step(1, 1);
    pulses = 0;
    for (int i = 0; i < 257 * FRAME; i++) begin
      step(0, 1);
      if (fs) begin
        pulses++;
        if (pulses == 1)   chk("fc_first", fc, 1);
        if (pulses == 255) chk("fc_255", fc, 255);
        if (pulses == 256) chk("fc_wrap", fc, 0);
        if (pulses == 257) chk("fc_257", fc, 1);
      end
    end
    chk("fc_pulses", pulses, 257);
`else
    pulses = 0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
